// File: rtl/sqrwav_pkg.sv
// Shared types and field widths for the square-wave sequencer.
package sqrwav_pkg;

    localparam int MN_W  = 4;
    localparam int REP_W = 8;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} seq_state_t;

    typedef struct packed {
        logic [MN_W-1:0]  m;
        logic [MN_W-1:0]  n;
        logic [REP_W-1:0] reps;
    } seq_entry_t;

endpackage

// File: rtl/sqrwav_cfg_regfile.sv
// Sequence table: one synchronous write port, one combinational read port.
module sqrwav_cfg_regfile
    import sqrwav_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  seq_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output seq_entry_t    rdata
);

    seq_entry_t mem [DEPTH];

    // Contents are deliberately not reset; software programs the table before use.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sqrwav_seq_ctrl.sv
// Steps the square-wave generator's m/n through a programmed table, counting
// completed periods on the generator's wave output.
//   state | meaning
//   IDLE  | generator held in reset, waiting for start
//   LOAD  | one cycle: register the current entry, clear period counting
//   RUN   | generator free-running, falls of wave_in advance reps/entries
module sqrwav_seq_ctrl
    import sqrwav_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  MN_W  = 4,
    parameter int  REP_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [MN_W-1:0]  cfg_m,
    input  logic [MN_W-1:0]  cfg_n,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic [AW:0]      seq_len,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    input  logic             wave_in,
    output logic [MN_W-1:0]  m_out,
    output logic [MN_W-1:0]  n_out,
    output logic             gen_hold,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    cur_idx
);

    seq_state_t       state, state_nxt;
    seq_entry_t       wr_entry, rd_entry;
    logic [AW:0]      len_q, len_clamped;
    logic             loop_q;
    logic [REP_W-1:0] reps_q, rep_cnt;
    logic [REP_W:0]   reps_eff;
    logic             wave_q, reload_q;
    logic             fall, rep_last, idx_last, accept;

    assign wr_entry = '{m: cfg_m, n: cfg_n, reps: cfg_reps};

    sqrwav_cfg_regfile #(.DEPTH(DEPTH)) u_regfile (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (wr_entry),
        .raddr (cur_idx),
        .rdata (rd_entry)
    );

    assign fall        = wave_q & ~wave_in;
    assign reps_eff    = (reps_q == '0) ? (REP_W+1)'(1) : {1'b0, reps_q};
    assign rep_last    = ({1'b0, rep_cnt} + (REP_W+1)'(1)) >= reps_eff;
    assign idx_last    = ({1'b0, cur_idx} + (AW+1)'(1)) >= len_q;
    assign len_clamped = (seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : seq_len;
    assign accept      = start && !stop && (seq_len != '0);

    assign gen_hold = (state != RUN);
    assign busy     = (state == LOAD) || (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = stop ? IDLE : RUN;
            RUN: begin
                if (stop)                                      state_nxt = IDLE;
                else if (fall && rep_last && idx_last && !loop_q) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The entry switch is deferred one cycle (reload_q) so the table is read at the new cur_idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out    <= '0;
            n_out    <= '0;
            reps_q   <= '0;
            rep_cnt  <= '0;
            cur_idx  <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            wave_q   <= 1'b0;
            reload_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    wave_q   <= 1'b0;
                    reload_q <= 1'b0;
                    if (accept) begin
                        len_q   <= len_clamped;
                        loop_q  <= loop;
                        cur_idx <= '0;
                    end
                end
                LOAD: begin
                    m_out    <= rd_entry.m;
                    n_out    <= rd_entry.n;
                    reps_q   <= rd_entry.reps;
                    rep_cnt  <= '0;
                    wave_q   <= 1'b0;
                    reload_q <= 1'b0;
                end
                RUN: begin
                    wave_q   <= wave_in;
                    reload_q <= 1'b0;
                    if (reload_q) begin
                        m_out  <= rd_entry.m;
                        n_out  <= rd_entry.n;
                        reps_q <= rd_entry.reps;
                    end
                    if (!stop && fall) begin
                        if (!rep_last) begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end else if (!idx_last) begin
                            cur_idx  <= cur_idx + AW'(1);
                            rep_cnt  <= '0;
                            reload_q <= 1'b1;
                        end else if (loop_q) begin
                            cur_idx  <= '0;
                            rep_cnt  <= '0;
                            reload_q <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    wave_q   <= 1'b0;
                    reload_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
